mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit: the producer side of the MEM/WB pipeline register.
//  Takes the EX/MEM fields, runs a valid/ready transaction on the data-memory bus,
//  aligns and extends load data, and drives the MEM->WB fields.
//  Stalls the upstream pipeline while a memory access is outstanding.
//  While stalled, presents a bubble to MEM/WB, which has no enable.
// PARAMETERS
//  RESP_TIMEOUT  255  cycles allowed in WAIT_ACC+WAIT_RESP before abort; 0 = no timeout
//  CNT_W         8    width of timeout counter; must satisfy 2**CNT_W > RESP_TIMEOUT
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   asynchronous, active-high reset
//  ex_valid         in   1   EX/MEM holds a real instruction
//  ex_mem_read      in   1   load
//  ex_mem_write     in   1   store; never set together with ex_mem_read
//  ex_funct3        in   3   width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ex_alu_res       in   32  effective address / ALU result
//  ex_store_data    in   32  rs2 value for stores
//  ex_rd            in   5   destination register
//  ex_mem_to_reg    in   1   WB selects memory data
//  ex_reg_write     in   1   WB writes rd
//  dmem_req_valid   out  1   request valid
//  dmem_req_ready   in   1   request accepted when valid&ready
//  dmem_req_we      out  1   1 = store
//  dmem_req_addr    out  32  word address: {ex_alu_res[31:2],2'b00}
//  dmem_req_wdata   out  32  store data replicated across lanes
//  dmem_req_wstrb   out  4   byte enables; 0 for loads
//  dmem_resp_valid  in   1   load data valid, one-cycle pulse
//  dmem_resp_rdata  in   32  load word
//  mem_mem_to_reg   out  1   to MEM/WB
//  mem_reg_write    out  1   to MEM/WB
//  mem_read_data    out  32  aligned/extended load data to MEM/WB
//  mem_alu_res      out  32  ex_alu_res passthrough to MEM/WB
//  mem_rd           out  5   to MEM/WB
//  stall_o          out  1   freeze PC, IF/ID, ID/EX, EX/MEM
//  mem_exc_o        out  1   one-cycle pulse: misaligned or illegal funct3
//  bus_err_o        out  1   one-cycle pulse: timeout abort
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, latched funct3/offset=0.
//   All req outputs, stall_o, exc/err, reg_write, mem_to_reg read 0.
//   mem_read_data=0. mem_alu_res and mem_rd are combinational passthroughs.
//  Mem op = ex_valid & (ex_mem_read|ex_mem_write). Non-mem op: combinational passthrough.
//   No stall; mem_read_data=0.
//  Checks: misaligned = H/HU with addr[0]!=0, or W with addr[1:0]!=0.
//   Illegal = load funct3 not in {000,001,010,100,101}, or store funct3 not in {000,001,010}.
//   Either raises mem_exc_o for 1 cycle. No request, no stall; reg_write and mem_to_reg forced 0.
//  FSM (3 states):
//   IDLE: valid mem op that passes checks drives dmem_req_valid combinationally.
//    Latch funct3 and addr[1:0].
//    Store accepted this cycle: completes, zero stall.
//    Load accepted: go to WAIT_RESP.
//    Not accepted: go to WAIT_ACC.
//   WAIT_ACC: hold req_valid and all req fields stable until ready.
//    Then store -> IDLE, load -> WAIT_RESP.
//   WAIT_RESP: req_valid=0. On resp_valid, present formatted data with reg_write and
//    mem_to_reg from ex_*; stall_o=0 this cycle; go to IDLE.
//  stall_o = mem op & !(store accepted) & !(resp_valid in WAIT_RESP) & !abort & !exc.
//   Best-case load latency: 1 stall cycle (accept @0, resp @1).
//  Bubble: while stall_o=1, mem_reg_write=0 and mem_mem_to_reg=0.
//  Stores: wstrb SB = 4'b0001<<off; SH = off[1] ? 1100 : 0011; SW = 1111.
//   wdata SB = {4{d[7:0]}}; SH = {2{d[15:0]}}; SW = d.
//  Loads: select byte/half by latched offset. B/H sign-extend; BU/HU zero-extend.
//  Timeout (RESP_TIMEOUT>0): counter clears on entering WAIT_ACC, increments each
//   cycle in WAIT_ACC/WAIT_RESP.
//   On reaching RESP_TIMEOUT: drop req_valid, pulse bus_err_o, complete with
//   reg_write=0, go to IDLE.
//   A late resp_valid while in IDLE is ignored.
//  Simultaneous: resp_valid is never expected in the accept cycle. resp_valid while
//   not in WAIT_RESP is ignored. Response beats timeout in the same cycle.
//  Reset mid-transaction: async return to IDLE, req_valid drops immediately;
//   the memory side discards the abandoned request.
// STRUCTURE
//  riscv_pkg: funct3 width localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the
//   lsu_state_t encoding {IDLE, WAIT_ACC, WAIT_RESP}.
//  Sub-module lsu_load_align (combinational): rdata, offset, funct3 -> 32-bit load value.
//  FSM, counter, strobe/wdata generation and bubble logic stay in mem_stage_lsu.
// TESTING
//  1. LW addr 0x100, ready=1, resp next cycle 0xDEADBEEF -> 1 stall cycle;
//     mem_read_data=0xDEADBEEF, reg_write=1.
//  2. LB addr 0x103, rdata 0x80FF_0000 -> 0xFFFFFF80. LBU same -> 0x00000080.
//     LHU addr 0x102 -> 0x000080FF.
//  3. SB addr 0x201, data 0x12345678, ready held low 3 cycles -> stall 3 cycles;
//     wstrb=0010, wdata=0x78787878, addr=0x200 stable.
//  4. LW addr 0x102 -> mem_exc_o pulse, no dmem_req_valid, reg_write=0, no stall.
//  5. RESP_TIMEOUT=4, load accepted, no resp -> bus_err_o pulse after 4 cycles;
//     reg_write=0; IDLE; later stray resp ignored.
//  6. rst asserted in WAIT_ACC -> req_valid and stall_o drop async; after release,
//     ADD passes through with zero stall.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions.
// Load/store width codes and LSU state encoding.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ACC,
      WAIT_RESP
   } lsu_state_t;

   function automatic logic f3_load_ok(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   function automatic logic f3_store_ok(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment and sign/zero extension.
// Picks the byte/half lane by address offset.
module lsu_load_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane select from the latched byte offset
   always_comb begin
      byte_s = rdata_i[8*off_i +: 8];
      half_s = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   // Width decode and extension
   always_comb begin
      data_o = '0;
      unique case (funct3_i)
         F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
         F3_H:    data_o = {{16{half_s[15]}}, half_s};
         F3_W:    data_o = rdata_i;
         F3_BU:   data_o = {24'd0, byte_s};
         F3_HU:   data_o = {16'd0, half_s};
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit feeding the MEM/WB register.
// Runs the dmem handshake and stalls upstream while busy.
module mem_stage_lsu
   import riscv_pkg::*;
#(
   parameter int unsigned RESP_TIMEOUT = 255,
   parameter int unsigned CNT_W        = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_alu_res,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_to_reg,
   input  logic        ex_reg_write,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_req_we,
   output logic [31:0] dmem_req_addr,
   output logic [31:0] dmem_req_wdata,
   output logic [3:0]  dmem_req_wstrb,
   input  logic        dmem_resp_valid,
   input  logic [31:0] dmem_resp_rdata,
   output logic        mem_mem_to_reg,
   output logic        mem_reg_write,
   output logic [31:0] mem_read_data,
   output logic [31:0] mem_alu_res,
   output logic [4:0]  mem_rd,
   output logic        stall_o,
   output logic        mem_exc_o,
   output logic        bus_err_o
);

   lsu_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       f3_q, f3_d;
   logic [1:0]       off_q, off_d;

   logic        mem_op;
   logic        illegal;
   logic        misal;
   logic        exc;
   logic        to_hit;
   logic        resp_ok;
   logic        abort;
   logic        req_v;
   logic        acc;
   logic        st_done;
   logic [31:0] ld_data;

   lsu_load_align u_align (
      .rdata_i  (dmem_resp_rdata),
      .off_i    (off_q),
      .funct3_i (f3_q),
      .data_o   (ld_data)
   );

   // Operation checks and handshake qualifiers; reset silences everything
   always_comb begin
      mem_op  = ex_valid & (ex_mem_read | ex_mem_write);
      illegal = ex_mem_read ? !f3_load_ok(ex_funct3)
                            : !f3_store_ok(ex_funct3);
      misal   = ((ex_funct3[1:0] == 2'b01) & ex_alu_res[0]) |
                ((ex_funct3[1:0] == 2'b10) & (|ex_alu_res[1:0]));
      exc     = !rst & mem_op & (state_q == IDLE) & (illegal | misal);
      to_hit  = (RESP_TIMEOUT != 0) &&
                (cnt_q == CNT_W'(RESP_TIMEOUT));
      resp_ok = (state_q == WAIT_RESP) & dmem_resp_valid;
      abort   = !rst & (state_q != IDLE) & to_hit & !resp_ok;
      req_v   = !rst & mem_op &
                (((state_q == IDLE) & !exc) |
                 ((state_q == WAIT_ACC) & !abort));
      acc     = req_v & dmem_req_ready;
      st_done = acc & ex_mem_write;
      stall_o = !rst & mem_op & !st_done & !resp_ok & !abort & !exc;
   end

   // Next state, timeout counter and load format latch
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      off_d   = off_q;
      unique case (state_q)
         IDLE: begin
            if (req_v) begin
               f3_d  = ex_funct3;
               off_d = ex_alu_res[1:0];
               cnt_d = '0;
               if (!acc)
                  state_d = WAIT_ACC;
               else if (ex_mem_read)
                  state_d = WAIT_RESP;
            end
         end
         WAIT_ACC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (abort)
               state_d = IDLE;
            else if (acc)
               state_d = ex_mem_read ? WAIT_RESP : IDLE;
         end
         WAIT_RESP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (resp_ok | abort)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         f3_q    <= '0;
         off_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
      end
   end

   // Request fields, stores replicate data across lanes
   always_comb begin
      dmem_req_valid = req_v;
      dmem_req_we    = req_v & ex_mem_write;
      dmem_req_addr  = req_v ? {ex_alu_res[31:2], 2'b00} : '0;
      dmem_req_wstrb = '0;
      dmem_req_wdata = '0;
      if (req_v & ex_mem_write) begin
         unique case (ex_funct3[1:0])
            2'b00: begin
               dmem_req_wstrb = 4'b0001 << ex_alu_res[1:0];
               dmem_req_wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
               dmem_req_wstrb = ex_alu_res[1] ? 4'b1100 : 4'b0011;
               dmem_req_wdata = {2{ex_store_data[15:0]}};
            end
            default: begin
               dmem_req_wstrb = 4'b1111;
               dmem_req_wdata = ex_store_data;
            end
         endcase
      end
   end

   // MEM/WB fields: bubble while stalled, kill on exception or abort
   always_comb begin
      mem_reg_write  = !rst & ex_valid & ex_reg_write &
                       !stall_o & !exc & !abort;
      mem_mem_to_reg = !rst & ex_valid & ex_mem_to_reg &
                       !stall_o & !exc & !abort;
      mem_read_data  = (!rst & resp_ok) ? ld_data : '0;
      mem_alu_res    = ex_alu_res;
      mem_rd         = ex_rd;
      mem_exc_o      = exc;
      bus_err_o      = abort;
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu.
// Random instructions and memory timing against a transaction model.
module tb_mem_stage_lsu;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_mem_read, ex_mem_write;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_alu_res, ex_store_data;
   logic [4:0]  ex_rd;
   logic        ex_mem_to_reg, ex_reg_write;
   logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
   logic [31:0] dmem_req_addr, dmem_req_wdata;
   logic [3:0]  dmem_req_wstrb;
   logic        dmem_resp_valid;
   logic [31:0] dmem_resp_rdata;
   logic        mem_mem_to_reg, mem_reg_write;
   logic [31:0] mem_read_data, mem_alu_res;
   logic [4:0]  mem_rd;
   logic        stall_o, mem_exc_o, bus_err_o;

   always #5 clk = ~clk;

   mem_stage_lsu #(.RESP_TIMEOUT(TO), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
      .ex_alu_res(ex_alu_res), .ex_store_data(ex_store_data),
      .ex_rd(ex_rd), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_reg_write(ex_reg_write),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
      .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
      .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
      .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write),
      .mem_read_data(mem_read_data), .mem_alu_res(mem_alu_res),
      .mem_rd(mem_rd), .stall_o(stall_o),
      .mem_exc_o(mem_exc_o), .bus_err_o(bus_err_o)
   );

   typedef struct {
      int          stall;
      bit          exc;
      bit          err;
      bit          rw;
      bit          m2r;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [4:0]  rd;
      bit          unacc;
   } cmp_t;

   typedef struct {
      logic [31:0] addr;
      bit          we;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } req_t;

   cmp_t cq[$];
   req_t rq[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 0;
   int   stall_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] fmt_load(input logic [2:0] f3,
                                            input int off,
                                            input logic [31:0] w);
      logic [31:0] v;
      v = w >> (8 * off);
      case (f3)
         3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
         3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
         3'd4: v = v % 256;
         3'd5: v = v % 65536;
         default: v = w;
      endcase
      return v;
   endfunction

   // Request monitor and completion monitor
   always @(negedge clk) begin
      if (mon_en) begin
         if (dmem_req_valid) begin
            if (rq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req: got addr %h expected none",
                        dmem_req_addr);
            end else begin
               chk("req_addr", dmem_req_addr, rq[0].addr);
               chk("req_we", 32'(dmem_req_we), 32'(rq[0].we));
               chk("req_wstrb", 32'(dmem_req_wstrb), 32'(rq[0].strb));
               if (rq[0].we)
                  chk("req_wdata", dmem_req_wdata, rq[0].wdata);
               if (dmem_req_ready)
                  void'(rq.pop_front());
            end
         end
         if (ex_valid) begin
            if (stall_o) begin
               stall_cnt++;
               chk("bubble", 32'({mem_reg_write, mem_mem_to_reg}), 32'd0);
            end else begin
               if (cq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_completion: got rd %0d expected none",
                           mem_rd);
               end else begin
                  chk("stall_cycles", 32'(stall_cnt), 32'(cq[0].stall));
                  chk("mem_exc", 32'(mem_exc_o), 32'(cq[0].exc));
                  chk("bus_err", 32'(bus_err_o), 32'(cq[0].err));
                  chk("reg_write", 32'(mem_reg_write), 32'(cq[0].rw));
                  chk("mem_to_reg", 32'(mem_mem_to_reg), 32'(cq[0].m2r));
                  chk("read_data", mem_read_data, cq[0].rdata);
                  chk("alu_res", mem_alu_res, cq[0].alu);
                  chk("rd", 32'(mem_rd), 32'(cq[0].rd));
                  if (cq[0].unacc && rq.size() != 0)
                     void'(rq.pop_front());
                  void'(cq.pop_front());
               end
               stall_cnt = 0;
            end
         end
      end
   end

   // One instruction: model its outcome, then drive it and the memory side
   task automatic issue(input bit v, input bit ld, input bit st,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] word,
                        input int dA, input int dR, input logic [4:0] rd,
                        input bit rwb, input bit m2r);
      cmp_t c;
      req_t r;
      int   fin;
      int   size;
      int   off;
      bit   bad;
      bit   mem;
      mem     = v && (ld || st);
      c.alu   = addr;
      c.rd    = rd;
      c.exc   = 0;
      c.err   = 0;
      c.unacc = 0;
      c.rdata = 0;
      c.rw    = v && rwb;
      c.m2r   = v && m2r;
      fin     = 0;
      if (mem) begin
         size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
         off  = addr % 4;
         bad  = ld ? !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                   : (f3 > 3'd2);
         bad  = bad || (addr % size != 0);
         if (bad) begin
            c.exc = 1;
            c.rw  = 0;
            c.m2r = 0;
         end else begin
            r.addr  = addr - off;
            r.we    = st;
            r.strb  = 0;
            r.wdata = 0;
            if (st) begin
               if (size == 1) begin
                  r.strb  = 4'(1 << off);
                  r.wdata = (sd % 256) * 32'h0101_0101;
               end else if (size == 2) begin
                  r.strb  = 4'(3 << off);
                  r.wdata = (sd % 65536) * 32'h0001_0001;
               end else begin
                  r.strb  = 4'hF;
                  r.wdata = sd;
               end
            end
            rq.push_back(r);
            if (dA > TO) begin
               fin     = TO + 1;
               c.err   = 1;
               c.unacc = 1;
            end else if (st) begin
               fin = dA;
            end else if (dA + dR <= TO + 1) begin
               fin     = dA + dR;
               c.rdata = fmt_load(f3, off, word);
            end else begin
               fin   = TO + 1;
               c.err = 1;
            end
            if (c.err) begin
               c.rw  = 0;
               c.m2r = 0;
            end
         end
      end
      c.stall = fin;
      if (v)
         cq.push_back(c);
      for (int k = 0; k <= fin; k++) begin
         ex_valid        = v;
         ex_mem_read     = ld;
         ex_mem_write    = st;
         ex_funct3       = f3;
         ex_alu_res      = addr;
         ex_store_data   = sd;
         ex_rd           = rd;
         ex_reg_write    = rwb;
         ex_mem_to_reg   = m2r;
         dmem_req_ready  = mem && !c.exc && (k == dA);
         dmem_resp_valid = (mem && ld && !c.exc && (k == dA + dR)) ||
                           (!mem && ($urandom % 2 == 1));
         dmem_resp_rdata = (mem && ld) ? word : $urandom;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          kind;
      rst             = 1'b1;
      ex_valid        = 0;
      ex_mem_read     = 0;
      ex_mem_write    = 0;
      ex_funct3       = 0;
      ex_alu_res      = 0;
      ex_store_data   = 0;
      ex_rd           = 0;
      ex_mem_to_reg   = 0;
      ex_reg_write    = 0;
      dmem_req_ready  = 0;
      dmem_resp_valid = 0;
      dmem_resp_rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_valid", 32'(dmem_req_valid), 32'd0);
      chk("rst_wstrb", 32'(dmem_req_wstrb), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_exc_err", 32'({mem_exc_o, bus_err_o}), 32'd0);
      chk("rst_wb_ctl", 32'({mem_reg_write, mem_mem_to_reg}), 32'd0);
      chk("rst_read_data", mem_read_data, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      mon_en = 1;

      issue(1, 1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 1, 5'd5, 1, 1);
      issue(1, 1, 0, 3'd0, 32'h103, 0, 32'h80FF0000, 0, 1, 5'd6, 1, 1);
      issue(1, 1, 0, 3'd4, 32'h103, 0, 32'h80FF0000, 0, 2, 5'd7, 1, 1);
      issue(1, 1, 0, 3'd5, 32'h102, 0, 32'h80FF0000, 1, 1, 5'd8, 1, 1);
      issue(1, 0, 1, 3'd0, 32'h201, 32'h12345678, 0, 3, 1, 5'd0, 0, 0);
      issue(1, 1, 0, 3'd2, 32'h102, 0, 32'h0, 0, 1, 5'd9, 1, 1);
      issue(1, 1, 0, 3'd2, 32'h100, 0, 32'h0, 0, 50, 5'd10, 1, 1);
      issue(1, 0, 0, 3'd0, 32'h44, 0, 32'h0, 0, 1, 5'd11, 1, 0);

      for (int i = 0; i < 300; i++) begin
         kind = $urandom % 8;
         if ($urandom % 5 == 0)
            f3 = 3'($urandom);
         else
            case ($urandom % 5)
               0: f3 = 3'd0;
               1: f3 = 3'd1;
               2: f3 = 3'd2;
               3: f3 = 3'd4;
               default: f3 = 3'd5;
            endcase
         a = $urandom & 32'hFFFF_FFFC;
         if ($urandom % 4 == 0 || f3 % 4 == 0)
            a = a + ($urandom % 4);
         else if (f3 % 4 == 1)
            a = a + 2 * ($urandom % 2);
         if (kind == 0)
            issue(0, 0, 0, f3, a, 0, 0, 0, 1, 5'd0, 0, 0);
         else if (kind < 3)
            issue(1, 0, 0, f3, a, $urandom, 0, 0, 1,
                  5'($urandom), 1'($urandom), 1'($urandom));
         else if (kind < 6)
            issue(1, 1, 0, f3, a, $urandom, $urandom,
                  $urandom % 7, 1 + $urandom % 5,
                  5'($urandom), 1, 1);
         else
            issue(1, 0, 1, f3 % 3, a, $urandom, 0,
                  $urandom % 7, 1, 5'($urandom), 0, 0);
      end
      repeat (3)
         issue(0, 0, 0, 3'd0, 0, 0, 0, 0, 1, 5'd0, 0, 0);
      chk("cq_drained", 32'(cq.size()), 32'd0);
      chk("rq_drained", 32'(rq.size()), 32'd0);

      mon_en          = 0;
      ex_valid        = 1;
      ex_mem_read     = 1;
      ex_mem_write    = 0;
      ex_funct3       = 3'd2;
      ex_alu_res      = 32'h300;
      ex_reg_write    = 1;
      ex_mem_to_reg   = 1;
      dmem_req_ready  = 0;
      dmem_resp_valid = 0;
      @(posedge clk);
      #1;
      chk("wait_acc_req", 32'(dmem_req_valid), 32'd1);
      chk("wait_acc_stall", 32'(stall_o), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_req", 32'(dmem_req_valid), 32'd0);
      chk("async_rst_stall", 32'(stall_o), 32'd0);
      ex_valid = 0;
      @(posedge clk);
      #1;
      rst             = 1'b0;
      ex_valid        = 1;
      ex_mem_read     = 0;
      ex_rd           = 5'd7;
      ex_alu_res      = 32'h1234;
      ex_mem_to_reg   = 0;
      dmem_resp_valid = 1;
      dmem_resp_rdata = 32'hCAFEF00D;
      #1;
      chk("add_stall", 32'(stall_o), 32'd0);
      chk("add_reg_write", 32'(mem_reg_write), 32'd1);
      chk("add_rd", 32'(mem_rd), 32'd7);
      chk("add_alu", mem_alu_res, 32'h1234);
      chk("add_read_data", mem_read_data, 32'd0);
      chk("add_no_req", 32'(dmem_req_valid), 32'd0);
      @(posedge clk);
      #1;
      dmem_resp_valid = 0;
      chk("add_stall_next", 32'(stall_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
